// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: issues word fetches, buffers responses in a DEPTH-entry FIFO, flushes on redirect.
// Optional performance counters are enabled by defining IFU_PERF_EN.
module ifu_prefetch #(
    parameter int XLEN = 32,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst_data,
    output logic [XLEN-1:0] inst_pc
`ifdef IFU_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_flushed,
    output logic [31:0]     perf_stall
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
    logic [XLEN-1:0] rsp_pc_reg, rsp_pc_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [CW-1:0]   live_reg, live_next;
    logic [CW-1:0]   drop_reg, drop_next;
    logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;

    logic [31:0]     data_mem [DEPTH];
    logic [XLEN-1:0] pc_mem [DEPTH];

    logic credit_ok;
    logic accept;
    logic rsp_drop;
    logic rsp_live;
    logic push;
    logic pop;
    logic [XLEN-1:0] redirect_aligned;

    always_comb begin
        // Buffered plus in-flight live requests must fit in the FIFO; flushed ones cost nothing.
        credit_ok        = ({1'b0, count_reg} + {1'b0, live_reg}) < (CW+1)'(DEPTH);
        imem_req_valid   = !reset && !redirect_valid && credit_ok;
        imem_req_addr    = fetch_pc_reg;
        accept           = imem_req_valid && imem_req_ready;
        rsp_drop         = imem_rsp_valid && (drop_reg != '0);
        rsp_live         = imem_rsp_valid && (drop_reg == '0) && (live_reg != '0);
        inst_valid       = (count_reg != '0);
        pop              = inst_valid && inst_ready && !redirect_valid;
        push             = rsp_live && !redirect_valid;
        redirect_aligned = redirect_pc & ALIGN_MASK;
        inst_data        = inst_valid ? data_mem[rd_ptr_reg] : '0;
        inst_pc          = inst_valid ? pc_mem[rd_ptr_reg] : '0;
    end

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        rsp_pc_next   = rsp_pc_reg;
        count_next    = count_reg;
        live_next     = live_reg;
        drop_next     = drop_reg;
        rd_ptr_next   = rd_ptr_reg;
        wr_ptr_next   = wr_ptr_reg;
        if (redirect_valid) begin
            // A response landing now settles against the pre-redirect live/drop totals.
            fetch_pc_next = redirect_aligned;
            rsp_pc_next   = redirect_aligned;
            count_next    = '0;
            rd_ptr_next   = '0;
            wr_ptr_next   = '0;
            live_next     = '0;
            drop_next     = drop_reg + live_reg - CW'(rsp_drop || rsp_live);
        end else begin
            if (accept) begin
                fetch_pc_next = fetch_pc_reg + PC_STEP;
            end
            if (push) begin
                rsp_pc_next = rsp_pc_reg + PC_STEP;
                wr_ptr_next = wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + AW'(1);
            end
            live_next  = live_reg + CW'(accept) - CW'(rsp_live);
            drop_next  = drop_reg - CW'(rsp_drop);
            count_next = count_reg + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_reg <= RESET_PC;
            rsp_pc_reg   <= RESET_PC;
            count_reg    <= '0;
            live_reg     <= '0;
            drop_reg     <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            rsp_pc_reg   <= rsp_pc_next;
            count_reg    <= count_next;
            live_reg     <= live_next;
            drop_reg     <= drop_next;
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
        end
    end

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= imem_rsp_data;
            pc_mem[wr_ptr_reg]   <= rsp_pc_reg;
        end
    end

`ifdef IFU_PERF_EN
    logic [31:0] perf_fetched_reg;
    logic [31:0] perf_flushed_reg;
    logic [31:0] perf_stall_reg;
    logic [31:0] flush_inc;

    always_comb begin
        // Flushed = buffered entries at redirect plus every response thrown away.
        flush_inc = (redirect_valid ? 32'(count_reg) : 32'd0)
                  + 32'(rsp_drop || (redirect_valid && rsp_live));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched_reg <= '0;
            perf_flushed_reg <= '0;
            perf_stall_reg   <= '0;
        end else begin
            perf_fetched_reg <= perf_fetched_reg + 32'(pop);
            perf_flushed_reg <= perf_flushed_reg + flush_inc;
            perf_stall_reg   <= perf_stall_reg + 32'(inst_ready && !inst_valid);
        end
    end

    assign perf_fetched = perf_fetched_reg;
    assign perf_flushed = perf_flushed_reg;
    assign perf_stall   = perf_stall_reg;
`endif

endmodule
